eth_tx_pkt_buf: RTL and testbench

//  Store-and-forward AXI4-Stream packet buffer between the encap TX master port and the 10G MAC TX slave.
//  A frame is released to the MAC only after it has been fully written, so m_axis_tvalid never drops mid-frame and the MAC cannot underrun.
//  A frame with tuser=1 on its last beat is discarded.
//  A frame larger than the buffer is discarded.
//  One instance per port.

---
 rtl/eth_tx_pkt_buf_if.sv | 14 +
 rtl/eth_tx_pkt_buf.sv | 154 +++++++++++++++
 tb/tb_eth_tx_pkt_buf.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_pkt_buf_if.sv
// rtl/eth_tx_pkt_buf_if.sv - AXI4-Stream bundle used on both sides of the TX packet buffer
interface eth_tx_pkt_buf_if #(
    parameter int DATA_W = 64
);
    logic                tvalid;
    logic                tready;
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic                tlast;
    logic                tuser;

    modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/eth_tx_pkt_buf.sv
// rtl/eth_tx_pkt_buf.sv - store-and-forward TX frame buffer; drops errored and oversize frames
module eth_tx_pkt_buf #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic             clk156,
    input  logic             eth_rst_n,
    eth_tx_pkt_buf_if.slave  s_axis,
    eth_tx_pkt_buf_if.master m_axis,
    output logic [CNT_W-1:0] frm_cnt,
    output logic [CNT_W-1:0] drop_err_cnt,
    output logic [CNT_W-1:0] drop_ovf_cnt
);
    localparam int KEEP_W = DATA_W / 8;
    localparam int PTR_W  = ADDR_W + 1;
    localparam int ENT_W  = DATA_W + KEEP_W + 1;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_SEND} rd_state_t;

    logic [ENT_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, wr_cmt_q, wr_cmt_d, rd_ptr_q;
    logic             drop_q, drop_d, rdy_q;
    logic [CNT_W-1:0] err_q, err_d, ovf_q, ovf_d, frm_q;
    logic             full, ovf_now, s_acc, wr_en, avail;
    logic [ENT_W-1:0] rd_ent, pf_q, out_q;
    logic             out_v_q;
    rd_state_t        state_q;

    // A frame that fills the buffer on its own can never be released, so it is swallowed.
    assign full    = (wr_ptr_q - rd_ptr_q) == PTR_FULL;
    assign ovf_now = full & (wr_cmt_q == rd_ptr_q) & ~drop_q;
    assign s_axis.tready = rdy_q & (~full | drop_q | ovf_now);
    assign s_acc   = s_axis.tvalid & s_axis.tready;
    assign wr_en   = s_acc & ~drop_q & ~ovf_now & ~(s_axis.tlast & s_axis.tuser);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        wr_cmt_d = wr_cmt_q;
        drop_d   = drop_q;
        err_d    = err_q;
        ovf_d    = ovf_q;
        if (drop_q || ovf_now) begin
            wr_ptr_d = wr_cmt_q;
            drop_d   = ~(s_acc & s_axis.tlast);
            if (s_acc && s_axis.tlast) begin
                ovf_d = ovf_q + CNT_ONE;
            end
        end else if (s_acc) begin
            if (s_axis.tlast && s_axis.tuser) begin
                wr_ptr_d = wr_cmt_q;
                err_d    = err_q + CNT_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                if (s_axis.tlast) begin
                    wr_cmt_d = wr_ptr_q + PTR_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk156 or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            wr_ptr_q <= '0;
            wr_cmt_q <= '0;
            drop_q   <= 1'b0;
            err_q    <= '0;
            ovf_q    <= '0;
            rdy_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            wr_cmt_q <= wr_cmt_d;
            drop_q   <= drop_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
            rdy_q    <= 1'b1;
        end
    end

    always_ff @(posedge clk156) begin
        if (wr_en) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= {s_axis.tlast, s_axis.tkeep, s_axis.tdata};
        end
    end

    assign avail  = wr_cmt_q != rd_ptr_q;
    assign rd_ent = mem[rd_ptr_q[ADDR_W-1:0]];

    // pf_q holds the beat after out_q; a non-last out_q always has a valid pf_q behind it.
    always_ff @(posedge clk156 or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            state_q  <= RD_IDLE;
            rd_ptr_q <= '0;
            pf_q     <= '0;
            out_q    <= '0;
            out_v_q  <= 1'b0;
            frm_q    <= '0;
        end else begin
            case (state_q)
                RD_IDLE: begin
                    if (avail) begin
                        pf_q     <= rd_ent;
                        rd_ptr_q <= rd_ptr_q + PTR_ONE;
                        state_q  <= RD_FETCH;
                    end
                end
                RD_FETCH: begin
                    out_q   <= pf_q;
                    out_v_q <= 1'b1;
                    if (!pf_q[ENT_W-1]) begin
                        pf_q     <= rd_ent;
                        rd_ptr_q <= rd_ptr_q + PTR_ONE;
                    end
                    state_q <= RD_SEND;
                end
                RD_SEND: begin
                    if (m_axis.tready) begin
                        if (out_q[ENT_W-1]) begin
                            frm_q   <= frm_q + CNT_ONE;
                            out_v_q <= 1'b0;
                            if (avail) begin
                                pf_q     <= rd_ent;
                                rd_ptr_q <= rd_ptr_q + PTR_ONE;
                                state_q  <= RD_FETCH;
                            end else begin
                                state_q <= RD_IDLE;
                            end
                        end else begin
                            out_q <= pf_q;
                            if (!pf_q[ENT_W-1]) begin
                                pf_q     <= rd_ent;
                                rd_ptr_q <= rd_ptr_q + PTR_ONE;
                            end
                        end
                    end
                end
                default: state_q <= RD_IDLE;
            endcase
        end
    end

    assign m_axis.tvalid = out_v_q;
    assign {m_axis.tlast, m_axis.tkeep, m_axis.tdata} = out_q;
    assign m_axis.tuser  = 1'b0;

    assign frm_cnt      = frm_q;
    assign drop_err_cnt = err_q;
    assign drop_ovf_cnt = ovf_q;
endmodule

// File: tb/tb_eth_tx_pkt_buf.sv
// tb/tb_eth_tx_pkt_buf.sv - directed scoreboard bench for eth_tx_pkt_buf (16-beat buffer)
module tb_eth_tx_pkt_buf;
    logic        clk;
    logic        eth_rst_n;
    logic [31:0] frm_cnt, drop_err_cnt, drop_ovf_cnt;

    eth_tx_pkt_buf_if #(.DATA_W(64)) s_if ();
    eth_tx_pkt_buf_if #(.DATA_W(64)) m_if ();

    eth_tx_pkt_buf #(.ADDR_W(4), .DATA_W(64), .CNT_W(32)) dut (
        .clk156       (clk),
        .eth_rst_n    (eth_rst_n),
        .s_axis       (s_if),
        .m_axis       (m_if),
        .frm_cnt      (frm_cnt),
        .drop_err_cnt (drop_err_cnt),
        .drop_ovf_cnt (drop_ovf_cnt)
    );

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    m_mode = 0;
    int    stalls = 0;
    int    tlast_cyc = 0;
    int    rise_cyc = -1;
    int    exp_frm = 0, exp_err = 0, exp_ovf = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // mode 0: always ready, 1: alternate 1/0, 2: never ready
    initial begin
        m_if.tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (m_mode)
                0:       m_if.tready = 1'b1;
                1:       m_if.tready = ~m_if.tready;
                default: m_if.tready = 1'b0;
            endcase
        end
    end

    initial begin : monitor
        logic        prev_v, prev_rdy, in_frame;
        logic [63:0] prev_d;
        beat_t       e;
        prev_v = 0; prev_rdy = 0; in_frame = 0; prev_d = '0;
        forever begin
            @(negedge clk);
            if (!eth_rst_n) begin
                prev_v = 0; prev_rdy = 0; in_frame = 0;
            end else begin
                if (prev_v && !prev_rdy) begin
                    chk("hold_valid", 64'(m_if.tvalid), 64'd1);
                    chk("hold_data", m_if.tdata, prev_d);
                end
                if (in_frame) chk("midframe_valid", 64'(m_if.tvalid), 64'd1);
                if (m_if.tvalid && !prev_v) rise_cyc = cyc;
                if (m_if.tvalid && m_if.tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got %0h want none", m_if.tdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", m_if.tdata, e.d);
                        chk("beat_keep", 64'(m_if.tkeep), 64'(e.k));
                        chk("beat_last", 64'(m_if.tlast), 64'(e.l));
                        chk("beat_user", 64'(m_if.tuser), 64'd0);
                    end
                    in_frame = !m_if.tlast;
                end
                prev_v = m_if.tvalid;
                prev_rdy = m_if.tready;
                prev_d = m_if.tdata;
            end
        end
    end

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
        int w;
        w = 0;
        s_if.tvalid = 1'b1;
        s_if.tdata = d;
        s_if.tkeep = k;
        s_if.tlast = l;
        s_if.tuser = u;
        while (!s_if.tready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (w >= 300) begin
            checks++;
            errors++;
            $display("FAIL s_accept: got stalled want accepted");
        end
        if (w > 0) stalls++;
        if (l) tlast_cyc = cyc;
        @(posedge clk);
        @(negedge clk);
        s_if.tvalid = 1'b0;
    endtask

    task automatic push_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        beat_t b;
        b.d = d;
        b.k = k;
        b.l = l;
        exp_q.push_back(b);
    endtask

    task automatic send_frame(input int n, input logic [63:0] base, input logic [7:0] lkeep,
                              input logic bad, input bit expect_out);
        for (int i = 0; i < n; i++) begin
            if (expect_out) push_beat(base + 64'(i), (i == n - 1) ? lkeep : 8'hFF, i == n - 1);
        end
        for (int i = 0; i < n; i++) begin
            send_beat(base + 64'(i), (i == n - 1) ? lkeep : 8'hFF, i == n - 1, bad && (i == n - 1));
        end
    endtask

    task automatic wait_drain(input string name);
        int w;
        w = 0;
        while ((exp_q.size() != 0 || m_if.tvalid) && w < 3000) begin
            @(negedge clk);
            w++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_frm_cnt"}, 64'(frm_cnt), 64'(exp_frm));
        chk({tag, "_drop_err_cnt"}, 64'(drop_err_cnt), 64'(exp_err));
        chk({tag, "_drop_ovf_cnt"}, 64'(drop_ovf_cnt), 64'(exp_ovf));
    endtask

    initial begin
        eth_rst_n = 1'b1;
        s_if.tvalid = 1'b0;
        s_if.tdata = '0;
        s_if.tkeep = '0;
        s_if.tlast = 1'b0;
        s_if.tuser = 1'b0;
        #1 eth_rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_s_tready", 64'(s_if.tready), 64'd0);
        chk("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        chk("rst_m_tdata", m_if.tdata, 64'd0);
        chk_counters("rst");
        eth_rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: 8-beat frame, partial keep on last, latency N+3
        m_mode = 0;
        send_frame(8, 64'h1111_0000_0000_0000, 8'h0F, 1'b0, 1'b1);
        exp_frm++;
        wait_drain("t1_drain");
        chk("t1_latency", 64'(rise_cyc), 64'(tlast_cyc + 3));
        chk_counters("t1");

        // 2: errored frame dropped, following good frame passes
        send_frame(8, 64'h2222_0000_0000_0000, 8'hFF, 1'b1, 1'b0);
        exp_err++;
        send_frame(4, 64'h2222_1000_0000_0000, 8'h03, 1'b0, 1'b1);
        exp_frm++;
        wait_drain("t2_drain");
        chk_counters("t2");

        // 3: 20-beat frame exceeds the 16-beat buffer; no stall, then a clean 3-beat frame
        stalls = 0;
        send_frame(20, 64'h3333_0000_0000_0000, 8'hFF, 1'b0, 1'b0);
        exp_ovf++;
        chk("t3_no_stall", 64'(stalls), 64'd0);
        send_frame(3, 64'h3333_1000_0000_0000, 8'h7F, 1'b0, 1'b1);
        exp_frm++;
        wait_drain("t3_drain");
        chk_counters("t3");

        // 4: 100 single-beat frames with output ready toggling
        m_mode = 1;
        for (int i = 0; i < 100; i++) begin
            send_frame(1, 64'h4444_0000_0000_0000 + 64'(i * 7), 8'hFF >> (i % 8), 1'b0, 1'b1);
        end
        exp_frm += 100;
        wait_drain("t4_drain");
        chk_counters("t4");

        // 5: fill with committed frames while the MAC stalls, then drain across the wrap
        m_mode = 2;
        repeat (3) @(negedge clk);
        for (int f = 0; f < 4; f++) begin
            send_frame(4, 64'h5555_0000_0000_0000 + 64'(f * 16), 8'hFF, 1'b0, 1'b1);
        end
        for (int i = 0; i < 4; i++) push_beat(64'h5555_1000_0000_0000 + 64'(i), 8'hFF, i == 3);
        send_beat(64'h5555_1000_0000_0000, 8'hFF, 1'b0, 1'b0);
        send_beat(64'h5555_1000_0000_0001, 8'hFF, 1'b0, 1'b0);
        s_if.tvalid = 1'b1;
        s_if.tdata = 64'h5555_1000_0000_0002;
        s_if.tkeep = 8'hFF;
        s_if.tlast = 1'b0;
        s_if.tuser = 1'b0;
        chk("t5_full_tready", 64'(s_if.tready), 64'd0);
        repeat (20) @(negedge clk);
        chk("t5_still_full", 64'(s_if.tready), 64'd0);
        chk("t5_no_output_frames", 64'(frm_cnt), 64'(exp_frm));
        m_mode = 0;
        send_beat(64'h5555_1000_0000_0002, 8'hFF, 1'b0, 1'b0);
        send_beat(64'h5555_1000_0000_0003, 8'hFF, 1'b1, 1'b0);
        exp_frm += 5;
        wait_drain("t5_drain");
        chk_counters("t5");

        // 6: reset with a frame half sent on the output and half written on the input
        m_mode = 1;
        send_frame(6, 64'h6666_0000_0000_0000, 8'hFF, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) send_beat(64'h6666_1000_0000_0000 + 64'(i), 8'hFF, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #2 eth_rst_n = 1'b0;
        #1;
        chk("t6_rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        chk("t6_rst_s_tready", 64'(s_if.tready), 64'd0);
        exp_q.delete();
        exp_frm = 0;
        exp_err = 0;
        exp_ovf = 0;
        chk_counters("t6_rst");
        repeat (3) @(negedge clk);
        #2 eth_rst_n = 1'b1;
        @(negedge clk);
        m_mode = 0;
        send_frame(2, 64'h6666_2000_0000_0000, 8'h01, 1'b0, 1'b1);
        exp_frm++;
        wait_drain("t6_drain");
        chk_counters("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
